// File: rtl/bcu_mem_responder.sv
// Off-chip memory responder: target side of the BCU memory interface, serving line reads and word writes.
// Optional MEM_RESP_ERRCHK_EN adds a sticky resp_error flag and out-of-range address handling.
module bcu_mem_responder #(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 7,
    parameter int WR_LAT = 3,
    parameter int BEATS  = 4
) (
    input  logic        sys_clk,
    input  logic        Resetn,
    input  logic [2:0]  mem_control,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_busout,
    input  logic [2:0]  mem_valid,
    output logic [31:0] mem_busin,
    output logic        mem_ack,
    output logic        mem_data_read_ack,
    output logic        mem_enable_n
`ifdef MEM_RESP_ERRCHK_EN
    ,
    output logic        resp_error
`endif
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LMAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW   = $clog2(LMAX + 1);
    localparam int BTW  = $clog2(BEATS + 1);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BEAT, WR_WAIT, WR_EN, DONE} state_t;
    typedef logic [31:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = 32'(i);
        return m;
    endfunction

    // Contents survive reset; the power-up image is mem[i] = i.
    mem_t mem = init_mem();

    state_t         state, state_d;
    logic [CW-1:0]  cnt, cnt_d;
    logic [BTW-1:0] beat, beat_d;
    logic [AW-1:0]  idx, idx_d, rd_idx, cmd_idx;
    logic           oor, oor_d, cmd_oor;
    logic [31:0]    busin_d, rd_word, wdata;
    logic           ack_d, rack_d, en_n_d, we;
    logic           unused_addr;

    assign cmd_idx     = mem_address[AW+1:2];
    assign unused_addr = ^{mem_address[31:AW+2], mem_address[1:0]};
`ifdef MEM_RESP_ERRCHK_EN
    logic err_d;
    assign cmd_oor = |mem_address[31:AW+2];
`else
    assign cmd_oor = 1'b0;
`endif

    assign rd_idx  = (idx & ~AW'(BEATS - 1)) + AW'(beat);
    assign rd_word = oor ? 32'hDEAD_BEEF : mem[rd_idx];
    // Byte lane write merges into the stored word; other legal masks replace it.
    assign wdata   = (mem_valid == 3'b001) ? {mem[idx][31:8], mem_busout[7:0]} : mem_busout;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        beat_d  = beat;
        idx_d   = idx;
        oor_d   = oor;
        busin_d = mem_busin;
        ack_d   = 1'b1;
        rack_d  = 1'b0;
        en_n_d  = 1'b1;
        we      = 1'b0;
`ifdef MEM_RESP_ERRCHK_EN
        err_d   = resp_error;
`endif
        case (state)
            IDLE: begin
                if (mem_control == 3'b001 || mem_control == 3'b010) begin
                    idx_d  = cmd_idx;
                    oor_d  = cmd_oor;
                    beat_d = '0;
                    if (mem_control == 3'b001) begin
                        cnt_d   = CW'(RD_LAT - 1);
                        state_d = RD_WAIT;
                    end else begin
                        cnt_d   = CW'(WR_LAT - 1);
                        state_d = WR_WAIT;
                    end
`ifdef MEM_RESP_ERRCHK_EN
                    if (cmd_oor) err_d = 1'b1;
                end else if (mem_control != 3'b000) begin
                    err_d = 1'b1;
`endif
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    state_d = RD_BEAT;
                    rack_d  = 1'b1;
                    busin_d = rd_word;
                    beat_d  = BTW'(1);
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RD_BEAT: begin
                if (beat == BTW'(BEATS)) begin
                    state_d = DONE;
                    ack_d   = 1'b0;
                end else begin
                    rack_d  = 1'b1;
                    busin_d = rd_word;
                    beat_d  = beat + 1'b1;
                end
            end
            WR_WAIT: begin
                if (cnt == '0) begin
                    state_d = WR_EN;
                    en_n_d  = 1'b0;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            WR_EN: begin
                if (beat == '0) begin
                    en_n_d = 1'b0;
                    beat_d = BTW'(1);
                end else begin
                    we      = !oor && mem_valid != 3'b000 && mem_valid != 3'b111;
                    state_d = DONE;
                    ack_d   = 1'b0;
                end
            end
            DONE: begin
                // Wait for NOP so a held command cannot start a second transaction.
                if (mem_control == 3'b000) state_d = IDLE;
                else ack_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!Resetn) begin
            state             <= IDLE;
            cnt               <= '0;
            beat              <= '0;
            idx               <= '0;
            oor               <= 1'b0;
            mem_busin         <= '0;
            mem_ack           <= 1'b1;
            mem_data_read_ack <= 1'b0;
            mem_enable_n      <= 1'b1;
`ifdef MEM_RESP_ERRCHK_EN
            resp_error        <= 1'b0;
`endif
        end else begin
            state             <= state_d;
            cnt               <= cnt_d;
            beat              <= beat_d;
            idx               <= idx_d;
            oor               <= oor_d;
            mem_busin         <= busin_d;
            mem_ack           <= ack_d;
            mem_data_read_ack <= rack_d;
            mem_enable_n      <= en_n_d;
`ifdef MEM_RESP_ERRCHK_EN
            resp_error        <= err_d;
`endif
        end
    end

    // A reset landing on the commit edge abandons the write.
    always_ff @(posedge sys_clk) begin
        if (Resetn && we) mem[idx] <= wdata;
    end
endmodule

// File: tb/tb_bcu_mem_responder.sv
// Bench for bcu_mem_responder: table of transactions checked against a word-array model and a read-beat scoreboard.
module tb_bcu_mem_responder;
    localparam int DEPTH = 256, RD_LAT = 7, WR_LAT = 3, BEATS = 4;

    logic        sys_clk = 1'b0;
    logic        Resetn = 1'b0;
    logic [2:0]  mem_control = '0;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_busout = '0;
    logic [2:0]  mem_valid = '0;
    logic [31:0] mem_busin;
    logic        mem_ack, mem_data_read_ack, mem_enable_n;
`ifdef MEM_RESP_ERRCHK_EN
    logic        resp_error;
`endif

    bcu_mem_responder #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .BEATS(BEATS)) dut (
        .sys_clk(sys_clk), .Resetn(Resetn), .mem_control(mem_control), .mem_address(mem_address),
        .mem_busout(mem_busout), .mem_valid(mem_valid), .mem_busin(mem_busin), .mem_ack(mem_ack),
        .mem_data_read_ack(mem_data_read_ack), .mem_enable_n(mem_enable_n)
`ifdef MEM_RESP_ERRCHK_EN
        , .resp_error(resp_error)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  v;
        bit          handshake;
    } vec_t;

    int          passed = 0, total = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] last_beat;
    bit          mon_en = 1'b0;
    vec_t        vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge sys_clk) begin
        if (mon_en && mem_data_read_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat: got %h expected no beat", mem_busin);
            end else begin
                chk("read_beat", mem_busin, exp_q.pop_front());
            end
        end
    end

    function automatic bit oor(input logic [31:0] a);
`ifdef MEM_RESP_ERRCHK_EN
        return a[31:2] >= 30'(DEPTH);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[31:2] % 30'(DEPTH));
    endfunction

    task automatic push_read(input logic [31:0] a);
        int base;
        base = widx(a) & ~(BEATS - 1);
        for (int b = 0; b < BEATS; b++) begin
            last_beat = oor(a) ? 32'hDEAD_BEEF : model[base + b];
            exp_q.push_back(last_beat);
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] v);
        if (oor(a) || v == 3'b000 || v == 3'b111) return;
        if (v == 3'b001) model[widx(a)][7:0] = d[7:0];
        else model[widx(a)] = d;
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d, input logic [2:0] v);
        mem_control = c; mem_address = a; mem_busout = d; mem_valid = v;
    endtask

    task automatic release_ctl();
        mem_control = 3'b000;
        @(posedge sys_clk); #1;
        chk("ack_release", {31'b0, mem_ack}, 32'd1);
    endtask

    // Cycle-exact handshake check, k counts edges after the sampling edge.
    task automatic timed(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] v, input int hold);
        logic [2:0] expv;
        drive(c, a, d, v);
        if (c == 3'b001) push_read(a);
        @(posedge sys_clk);
        for (int k = 1; k <= 13 + hold; k++) begin
            @(posedge sys_clk); #1;
            if (c == 3'b001)
                expv = {k >= RD_LAT && k < RD_LAT + BEATS, k < RD_LAT + BEATS, 1'b1};
            else
                expv = {1'b0, k < WR_LAT + 2, !(k == WR_LAT || k == WR_LAT + 1)};
            chk($sformatf("timing_k%0d_rack_ack_enn", k),
                {29'b0, mem_data_read_ack, mem_ack, mem_enable_n}, {29'b0, expv});
        end
        if (c == 3'b001) chk("busin_hold", mem_busin, last_beat);
        if (c == 3'b010) model_write(a, d, v);
        release_ctl();
    endtask

    task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d, input logic [2:0] v);
        int n;
        drive(c, a, d, v);
        if (c == 3'b001) push_read(a);
        n = 0;
        do begin
            @(posedge sys_clk); #1;
            n++;
        end while (mem_ack !== 1'b0 && n < 40);
        chk("done_reached", {31'b0, n < 40}, 32'd1);
        if (c == 3'b010) model_write(a, d, v);
        release_ctl();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'(i);
        vt[0]  = '{3'b001, 32'h0000_0000, 32'h0,         3'b000, 1'b1};
        vt[1]  = '{3'b010, 32'h0000_0014, 32'h1234_56AB, 3'b001, 1'b1};
        vt[2]  = '{3'b010, 32'h0000_0018, 32'h7777_7777, 3'b000, 1'b1};
        vt[3]  = '{3'b001, 32'h0000_0010, 32'h0,         3'b000, 1'b1};
        vt[4]  = '{3'b010, 32'h0000_03FC, 32'h5555_AAAA, 3'b010, 1'b1};
        vt[5]  = '{3'b001, 32'h0000_03F0, 32'h0,         3'b000, 1'b1};
        vt[6]  = '{3'b010, 32'h0000_040C, 32'h9999_9999, 3'b111, 1'b1};
        vt[7]  = '{3'b011, 32'h0000_0000, 32'h0,         3'b000, 1'b0};
        vt[8]  = '{3'b001, 32'h0000_0400, 32'h0,         3'b000, 1'b1};
        vt[9]  = '{3'b010, 32'h0000_000C, 32'hA5A5_0F0F, 3'b110, 1'b1};
        vt[10] = '{3'b111, 32'h0000_0004, 32'h0,         3'b010, 1'b0};
        vt[11] = '{3'b001, 32'h0000_000C, 32'h0,         3'b000, 1'b1};

        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_busin", mem_busin, 32'h0);
        chk("reset_rack_ack_enn", {29'b0, mem_data_read_ack, mem_ack, mem_enable_n}, 32'd3);
`ifdef MEM_RESP_ERRCHK_EN
        chk("reset_err", {31'b0, resp_error}, 32'd0);
`endif
        Resetn = 1'b1;
        mon_en = 1'b1;

        // Line read at 0x24 with the command held through DONE for 5 extra cycles.
        timed(3'b001, 32'h0000_0024, 32'h0, 3'b000, 5);
        timed(3'b010, 32'h0000_0008, 32'hCAFE_F00D, 3'b100, 0);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].handshake) begin
                issue(vt[i].c, vt[i].a, vt[i].d, vt[i].v);
            end else begin
                drive(vt[i].c, vt[i].a, vt[i].d, vt[i].v);
                for (int k = 0; k < 4; k++) begin
                    @(posedge sys_clk); #1;
                    chk("illegal_no_handshake", {29'b0, mem_data_read_ack, mem_ack, mem_enable_n}, 32'd3);
                end
                mem_control = 3'b000;
            end
        end

        // Reset on the commit edge of a write: target word must keep its value.
        drive(3'b010, 32'h0000_0020, 32'hFFFF_FFFF, 3'b100);
        n = 0;
        do begin
            @(posedge sys_clk); #1;
            n++;
        end while (mem_enable_n !== 1'b0 && n < 20);
        chk("wr_en_reached", {31'b0, n < 20}, 32'd1);
        @(posedge sys_clk); #1;
        chk("wr_en_second", {31'b0, mem_enable_n}, 32'd0);
        Resetn = 1'b0;
        mem_control = 3'b000;
        @(posedge sys_clk); #1;
        chk("midreset_rack_ack_enn", {29'b0, mem_data_read_ack, mem_ack, mem_enable_n}, 32'd3);
`ifdef MEM_RESP_ERRCHK_EN
        chk("midreset_err_clear", {31'b0, resp_error}, 32'd0);
`endif
        Resetn = 1'b1;
        issue(3'b001, 32'h0000_0020, 32'h0, 3'b000);
        chk("word8_after_reset", model[8], 32'd8);

`ifdef MEM_RESP_ERRCHK_EN
        mem_control = 3'b101;
        @(posedge sys_clk); #1;
        mem_control = 3'b000;
        @(posedge sys_clk); #1;
        chk("err_sticky", {31'b0, resp_error}, 32'd1);
`endif
        repeat (2) @(posedge sys_clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bcu_mem_responder.md
Name: bcu_mem_responder

Overview:
- Off-chip memory responder: the target end of the BCU memory interface, used as the system-memory model in BCU and full-chip benches.
- Decodes mem_control, services 4-beat line reads and single-word writes from an internal word array, and drives mem_ack, mem_data_read_ack, mem_enable_n and mem_busin with programmable latency.

Parameters:
DEPTH, 256, number of 32-bit words in the array; power of 2.
RD_LAT, 7, cycles from read-command sample to first data beat; must be at least 1.
WR_LAT, 3, cycles mem_enable_n is held high before the write-data window; must be at least 1.
BEATS, 4, words returned per read; power of 2, at most 4.

Ports:
sys_clk  in  1  clock; all logic on posedge.
Resetn  in  1  reset, synchronous, active-low.
mem_control  in  3  command: 000 NOP, 001 read block, 010 write block; other codes illegal.
mem_address  in  32  byte address; sampled with the command.
mem_busout  in  32  write data from the BCU.
mem_valid  in  3  write lane mask.
mem_busin  out  32  read data to the BCU.
mem_ack  out  1  1 = idle or busy; 0 = transaction complete.
mem_data_read_ack  out  1  1 = mem_busin valid this cycle.
mem_enable_n  out  1  0 = write-data window open.

Behaviour:
- Reset: Resetn is synchronous, active-low; clock sys_clk. Reset outputs are mem_busin=0, mem_ack=1, mem_data_read_ack=0, mem_enable_n=1, state IDLE. Reset applies mid-transaction: the transaction is abandoned and no write is committed. Array contents are unaffected by reset. At time zero mem[i]=i.
- Word index: idx = mem_address[31:2] mod DEPTH.
- Read line base: base = idx with the low log2(BEATS) bits cleared.
- All outputs are registered.
- FSM states: IDLE, RD_WAIT, RD_BEAT, WR_WAIT, WR_EN, DONE.
- IDLE, at each edge:
  - mem_control=001: latch address, cnt=RD_LAT-1, go to RD_WAIT.
  - mem_control=010: latch address, cnt=WR_LAT-1, go to WR_WAIT.
  - Otherwise stay in IDLE.
- RD_WAIT: hold outputs at idle values. When cnt=0, go to RD_BEAT with beat=0; otherwise decrement cnt.
- RD_BEAT: drive mem_data_read_ack=1 and mem_busin=mem[base+beat] for BEATS consecutive cycles. The last beat is followed by DONE.
- Read timing: command sampled at edge N gives beats in the cycles after edges N+RD_LAT .. N+RD_LAT+BEATS-1.
- WR_WAIT: mem_enable_n=1. When cnt=0, go to WR_EN; otherwise decrement cnt.
- WR_EN: mem_enable_n=0 for exactly 2 cycles. At the edge ending the second cycle, sample mem_busout and mem_valid, commit the write, and go to DONE.
- Write commit by mem_valid:
  - 001: write mem[idx][7:0] from mem_busout[7:0]; other bytes unchanged.
  - 010..110: write the full word mem[idx] from mem_busout.
  - 000 or 111: write suppressed; the handshake still completes.
- DONE: mem_ack=0, mem_enable_n=1, mem_data_read_ack=0. Stay until an edge samples mem_control=000, then go to IDLE with mem_ack=1. This prevents a held command from re-triggering.
- mem_control and mem_address changes during a transaction are ignored; the latched command runs to completion.
- Illegal codes (011..111) sampled in IDLE are treated as NOP.
- mem_busin holds its last beat value outside RD_BEAT.
- Throughput: one transaction at a time; no pipelining.

Optional Feature:
- Macro: MEM_RESP_ERRCHK_EN.
- Defined:
  - Adds output resp_error (1 bit). Its reset value is 0.
  - resp_error is sticky and cleared only by reset.
  - It sets when a command is sampled in IDLE with an illegal code, or with mem_address[31:2] >= DEPTH on a read or write.
  - An out-of-range read returns 32'hDEAD_BEEF on every beat. An out-of-range write is suppressed. The handshake timing is unchanged.
- Not defined: no resp_error port; addresses wrap modulo DEPTH; illegal codes are silently treated as NOP.

Test Plan:
- Read: mem_control=001 with address 0x24 at edge N, default parameters -> mem_data_read_ack=1 after edges N+7..N+10 with mem_busin 8, 9, 10, 11; mem_ack=0 from edge N+11 until control=000 is sampled, then mem_ack=1.
- Full-word write: mem_control=010, address 0x08, mem_valid=100, mem_busout=0xCAFE_F00D held -> mem_enable_n low after edges N+3 and N+4; DONE after edge N+5; a following read of line 0 returns beat 2 = 0xCAFE_F00D.
- Byte write then read: mem_valid=001, data 0x1234_56AB to word 5 -> mem[5]=0x0000_00AB; mem_valid=000 to word 6 -> mem[6] stays 6, handshake identical.
- Held command: mem_control kept at 001 through DONE for 5 cycles -> mem_ack stays 0 and no second read starts; control=000 -> IDLE.
- Reset mid-transaction: Resetn=0 during WR_EN -> next edge gives mem_ack=1, mem_enable_n=1; target word unchanged.
- With MEM_RESP_ERRCHK_EN: read at 0x400 (DEPTH=256) -> 4 beats of 0xDEAD_BEEF; resp_error=1 and stays set; control=011 also sets it and causes no handshake.
